// File: rtl/rdi_stall_sequencer_pkg.sv
// Shared types for the RDI stall sequencer: stall FSM encoding, requester
// indices (priority order) and RDI state codes used by the surrounding SM.
package rdi_stall_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck,
    StGrant
  } stall_state_e;

  // Requester bit positions; lower index wins arbitration.
  typedef enum int unsigned {
    ReqLinkReset = 0,
    ReqRetrain   = 1,
    ReqDisable   = 2,
    ReqL2        = 3,
    ReqL1        = 4
  } stall_req_idx_e;

  typedef enum logic [3:0] {
    RdiReset       = 4'h0,
    RdiActive      = 4'h1,
    RdiActivePmNak = 4'h3,
    RdiL1          = 4'h4,
    RdiL2          = 4'h8,
    RdiLinkReset   = 4'h9,
    RdiLinkError   = 4'ha,
    RdiRetrain     = 4'hb,
    RdiDisabled    = 4'hc
  } rdi_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdi_stall_sequencer_if.sv
// Stall handshake bundle between the RDI state machine / adapter pins and the
// stall sequencer. master = environment side, slave = sequencer side.
interface rdi_stall_sequencer_if
  import rdi_stall_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ = 5
);
  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] i_req;
  logic               i_lp_stallack;
  logic               o_pl_stallreq;
  logic               o_busy;
  logic [ID_W-1:0]    o_winner_id;
  logic [NUM_REQ-1:0] o_grant;
  logic               o_timeout;

  modport master (
    output i_req, i_lp_stallack,
    input  o_pl_stallreq, o_busy, o_winner_id, o_grant, o_timeout
  );

  modport slave (
    input  i_req, i_lp_stallack,
    output o_pl_stallreq, o_busy, o_winner_id, o_grant, o_timeout
  );

endinterface

// File: rtl/rdi_stall_sequencer_prio_arb.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module rdi_stall_sequencer_prio_arb #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_id
);

  // Scan from the lowest-priority end so the highest-priority hit is written last.
  always_comb begin
    o_valid = |i_req;
    o_id    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/rdi_stall_sequencer.sv
// RDI stall handshake owner: arbitrates stall requesters, runs the
// pl_stallreq/lp_stallack handshake and pulses a one-hot grant on completion.
// Optional abort timer enabled by defining STALL_TIMEOUT_EN.
module rdi_stall_sequencer
  import rdi_stall_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 5,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                 lclk,
  input logic                 sys_rst,
  rdi_stall_sequencer_if.slave stall_bus
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  stall_state_e       r_state;
  stall_state_e       w_state_d;
  logic [ID_W-1:0]    r_winner;
  logic               r_stallreq;
  logic               r_busy;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_timeout;

  logic               w_arb_valid;
  logic [ID_W-1:0]    w_arb_id;
  logic               w_latch;
  logic               w_abort;
  logic               w_timeout_hit;
  logic [NUM_REQ-1:0] w_winner_onehot;

  rdi_stall_sequencer_prio_arb #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .i_req  (stall_bus.i_req),
    .o_valid(w_arb_valid),
    .o_id   (w_arb_id)
  );

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned CNT_W = id_width(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_cnt;

  // Counts REQ cycles; held at zero elsewhere so it is clear on entry to REQ.
  always_ff @(posedge lclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (r_state != StReq) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign w_timeout_hit        = 1'b0;
`endif

  assign w_winner_onehot = NUM_REQ'(1) << r_winner;

  // Next-state logic; a stale ack in IDLE holds off arbitration, ack beats timeout.
  always_comb begin
    w_state_d = r_state;
    w_latch   = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_arb_valid && !stall_bus.i_lp_stallack) begin
          w_state_d = StReq;
          w_latch   = 1'b1;
        end
      end
      StReq: begin
        if (stall_bus.i_lp_stallack) begin
          w_state_d = StAck;
        end else if (w_timeout_hit) begin
          w_state_d = StIdle;
          w_abort   = 1'b1;
        end
      end
      StAck: begin
        if (!stall_bus.i_lp_stallack) w_state_d = StGrant;
      end
      StGrant: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State, frozen winner and registered outputs decoded from the next state.
  always_ff @(posedge lclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= StIdle;
      r_winner   <= '0;
      r_stallreq <= 1'b0;
      r_busy     <= 1'b0;
      r_grant    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      if (w_latch) r_winner <= w_arb_id;
      r_stallreq <= (w_state_d == StReq);
      r_busy     <= (w_state_d != StIdle);
      r_grant    <= (w_state_d == StGrant) ? w_winner_onehot : '0;
      r_timeout  <= w_abort;
    end
  end

  assign stall_bus.o_pl_stallreq = r_stallreq;
  assign stall_bus.o_busy        = r_busy;
  assign stall_bus.o_winner_id   = r_winner;
  assign stall_bus.o_grant       = r_grant;
  assign stall_bus.o_timeout     = r_timeout;

endmodule

// File: tb/tb_rdi_stall_sequencer.sv
// Scoreboard bench for rdi_stall_sequencer: the driver pushes the expected
// grant (lowest pending request) when it offers requests; a monitor pops and
// compares on every grant pulse. Cycle 1 is the cycle i_req is first presented.
module tb_rdi_stall_sequencer;
  import rdi_stall_sequencer_pkg::*;

  localparam int unsigned NUM_REQ = 5;
  localparam int unsigned ID_W    = id_width(NUM_REQ);
  localparam int          BUDGET  = 40;

  logic lclk    = 1'b0;
  logic sys_rst = 1'b1;
  always #5 lclk = ~lclk;

  rdi_stall_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();

  rdi_stall_sequencer #(
    .NUM_REQ    (NUM_REQ),
    .TIMEOUT_CYC(16)
  ) dut (
    .lclk     (lclk),
    .sys_rst  (sys_rst),
    .stall_bus(bus)
  );

  int                 n_vec = 0;
  int                 n_err = 0;
  int                 cyc   = 0;
  bit                 timeout_ok = 1'b0;
  logic [NUM_REQ-1:0] exp_q[$];
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] mon_exp;

  always @(posedge lclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] lowest(input logic [NUM_REQ-1:0] m);
    return m & (~m + NUM_REQ'(1));
  endfunction

  function automatic int idx_of(input logic [NUM_REQ-1:0] oh);
    for (int i = 0; i < int'(NUM_REQ); i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Monitor: every grant pulse must match the next queued expectation.
  always @(negedge lclk) begin
    if (!sys_rst) begin
      if (bus.o_timeout && !timeout_ok) check("unexpected_timeout", 32'(bus.o_timeout), 32'd0);
      if (|bus.o_grant) begin
        if (exp_q.size() == 0) begin
          check("grant_unexpected", 32'(bus.o_grant), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("grant", 32'(bus.o_grant), 32'(mon_exp));
        end
      end
    end
  end

  task automatic tick();
    @(negedge lclk);
  endtask

  // One full handshake for the current pending set.
  task automatic run_hs(input int stale, input int d1, input int d2, input bit withdraw,
                        input logic [NUM_REQ-1:0] arrive, input bit chk_lat);
    logic [NUM_REQ-1:0] win;
    int                 c0;
    int                 n;
    win = lowest(pend);
    exp_q.push_back(win);
    if (stale > 0) bus.i_lp_stallack = 1'b1;
    bus.i_req = pend;
    c0 = cyc;
    for (int i = 0; i < stale; i++) begin
      tick();
      check("stale_ack_stallreq", 32'(bus.o_pl_stallreq), 32'd0);
      check("stale_ack_busy", 32'(bus.o_busy), 32'd0);
    end
    bus.i_lp_stallack = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.o_pl_stallreq && n < BUDGET);
    check("stallreq_seen", 32'(bus.o_pl_stallreq), 32'd1);
    check("winner_id", 32'(bus.o_winner_id), 32'(idx_of(win)));
    check("busy_in_req", 32'(bus.o_busy), 32'd1);
    if (withdraw) pend &= ~win;
    pend |= arrive;
    bus.i_req = pend;
    for (int i = 0; i < d1; i++) begin
      tick();
      check("stallreq_hold", 32'(bus.o_pl_stallreq), 32'd1);
    end
    bus.i_lp_stallack = 1'b1;
    tick();
    check("stallreq_drop_on_ack", 32'(bus.o_pl_stallreq), 32'd0);
    for (int i = 1; i < d2; i++) tick();
    bus.i_lp_stallack = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.o_grant == '0 && n < BUDGET);
    check("grant_seen", 32'(|bus.o_grant), 32'd1);
    if (chk_lat) check("latency_cycles", 32'(cyc - c0 + 1), 32'd4);
    pend &= ~win;
    bus.i_req = pend;
    tick();
    check("busy_after_grant", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] arr;
    int                 n;
    bus.i_req         = '0;
    bus.i_lp_stallack = 1'b0;
    pend              = '0;
    #12;
    check("rst_stallreq", 32'(bus.o_pl_stallreq), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_grant", 32'(bus.o_grant), 32'd0);
    check("rst_winner", 32'(bus.o_winner_id), 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();

    // Single requester, minimum-latency adapter.
    pend = 5'b00100;
    run_hs(0, 0, 1, 1'b0, '0, 1'b1);
    // Simultaneous: bit 1 first, bit 4 still held gets a second handshake.
    pend = 5'b10010;
    run_hs(0, 0, 1, 1'b0, '0, 1'b0);
    run_hs(0, 1, 2, 1'b0, '0, 1'b0);
    // Stale ack in IDLE blocks arbitration until it drops.
    pend = 5'b00001;
    run_hs(3, 0, 1, 1'b0, '0, 1'b0);
    // Winner withdraws during REQ while a higher-priority request arrives.
    pend = 5'b01000;
    run_hs(0, 2, 1, 1'b1, 5'b00001, 1'b0);
    run_hs(0, 0, 1, 1'b0, '0, 1'b0);

    // Asynchronous reset in ACK aborts the handshake.
    pend = 5'b00100;
    bus.i_req = pend;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.o_pl_stallreq && n < BUDGET);
    bus.i_lp_stallack = 1'b1;
    tick();
    #2 sys_rst = 1'b1;
    #1;
    check("midrst_stallreq", 32'(bus.o_pl_stallreq), 32'd0);
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_grant", 32'(bus.o_grant), 32'd0);
    tick();
    bus.i_lp_stallack = 1'b0;
    sys_rst = 1'b0;
    run_hs(0, 0, 1, 1'b0, '0, 1'b0);

`ifdef STALL_TIMEOUT_EN
    // Ack never rises: 16 REQ cycles then a timeout pulse and no grant.
    timeout_ok = 1'b1;
    pend = 5'b00010;
    bus.i_req = pend;
    n = 0;
    for (int i = 0; i < BUDGET && !bus.o_timeout; i++) begin
      tick();
      if (bus.o_pl_stallreq) n++;
    end
    check("timeout_pulse", 32'(bus.o_timeout), 32'd1);
    check("timeout_req_cycles", 32'(n), 32'd16);
    check("timeout_busy", 32'(bus.o_busy), 32'd0);
    pend = '0;
    bus.i_req = pend;
    tick();
    timeout_ok = 1'b0;
`endif

    // Randomized episodes.
    for (int e = 0; e < 40; e++) begin
      if (pend == '0) pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      arr = ($urandom_range(0, 2) == 0) ? NUM_REQ'($urandom) : '0;
      run_hs(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
             ($urandom_range(0, 3) == 0), arr, 1'b0);
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
